// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for fifo_param: requests and data in, flags and pulses out.
// Latency: n/a (wiring only). Backpressure: reported through full/wr_err and empty/rd_err.
// The master modport is the client side; the FIFO uses the slave modport.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic [ADDR_WIDTH:0]   data_count;
    logic [2:0]            state;

    modport master (
        output wr_en, rd_en, d_in,
        input  d_out, full, empty, almost_full, almost_empty,
        input  wr_ack, wr_err, rd_ack, rd_err, data_count, state
    );

    modport slave (
        input  wr_en, rd_en, d_in,
        output d_out, full, empty, almost_full, almost_empty,
        output wr_ack, wr_err, rd_ack, rd_err, data_count, state
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with per-operation ack/err pulses and threshold flags.
// Latency: write visible to a read one edge later; d_out and acks registered, valid after the edge.
// Backpressure: writes when full and reads when empty are rejected with an err pulse, state untouched.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic          clk,
    input  logic          reset,
    fifo_param_if.slave   bus
);
    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        INIT   = 3'b000,
        WRITE  = 3'b001,
        WR_ERR = 3'b010,
        NO_OP  = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101,
        RDWR   = 3'b110
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] d_out_q;
    logic                  wr_ack_q;
    logic                  wr_err_q;
    logic                  rd_ack_q;
    logic                  rd_err_q;
    state_t                state_q;

    logic can_wr;
    logic can_rd;
    logic do_wr;
    logic do_rd;

    // Acceptance depends only on the pre-edge count, so a simultaneous read
    // never frees space for a write and a write never feeds a read (no bypass).
    assign can_wr = (count != DEPTH_C);
    assign can_rd = (count != '0);
    assign do_wr  = bus.wr_en && can_wr;
    assign do_rd  = bus.rd_en && can_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INIT;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            d_out_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ack_q <= do_wr;
            wr_err_q <= bus.wr_en && !can_wr;
            rd_ack_q <= do_rd;
            rd_err_q <= bus.rd_en && !can_rd;

            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                d_out_q <= mem[rd_ptr];
            end

            unique case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // Next state never looks at the current state, so an illegal
            // encoding simply falls through to the normal decode.
            unique case ({bus.wr_en, bus.rd_en})
                2'b00:   state_q <= NO_OP;
                2'b10:   state_q <= can_wr ? WRITE : WR_ERR;
                2'b01:   state_q <= can_rd ? READ : RD_ERR;
                default: state_q <= !can_rd ? WRITE : (!can_wr ? READ : RDWR);
            endcase
        end
    end

    // Storage is deliberately not reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem[wr_ptr] <= bus.d_in;
        end
    end

    assign bus.d_out        = d_out_q;
    assign bus.data_count   = count;
    assign bus.state        = state_q;
    assign bus.full         = (count == DEPTH_C);
    assign bus.empty        = (count == '0);
    assign bus.almost_full  = (count >= AF_C);
    assign bus.almost_empty = (count <= AE_C);
    assign bus.wr_ack       = wr_ack_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.rd_err       = rd_err_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed vector bench for fifo_param with default parameters (32-bit, 8 deep, AF 6, AE 2).
module tb_fifo_param;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    fifo_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    fifo_param #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [31:0] dout;
        logic [3:0]  cnt;
        logic [2:0]  st;
        logic [3:0]  fl;   // {full, empty, almost_full, almost_empty}
        logic [3:0]  ak;   // {wr_ack, wr_err, rd_ack, rd_err}
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    // Expected flags per occupancy 0..8, worked out by hand.
    logic [3:0] fl_tab [9] = '{4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                               4'b0000, 4'b0010, 4'b0010, 4'b1010};

    localparam logic [46:0] RST_V = {32'h0, 4'd0, 3'd0, 4'b0101, 4'b0000};

    vec_t tbl [$];

    function automatic vec_t mk(input logic w, input logic r, input logic [31:0] d,
                                input logic [31:0] q, input int c, input logic [2:0] s,
                                input logic [3:0] f, input logic [3:0] a);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.dout = q;
        v.cnt = 4'(c); v.st = s; v.fl = f; v.ak = a;
        return v;
    endfunction

    function automatic logic [46:0] observe();
        return {bus.d_out, bus.data_count, bus.state,
                bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
    endfunction

    task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic [31:0] d);
        bus.wr_en = w;
        bus.rd_en = r;
        bus.d_in  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_d;

        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;
        bus.d_in  = 32'hDEAD_BEEF;

        // Fill to full, then one rejected write.
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1, 0, 32'h11 * k, 32'h0, k, 3'd1, fl_tab[k], 4'b1000));
        tbl.push_back(mk(1, 0, 32'h99, 32'h0, 8, 3'd2, fl_tab[8], 4'b0100));
        // Drain in order, then one rejected read and an idle cycle.
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 1, 32'h0, 32'h11 * k, 8 - k, 3'd4, fl_tab[8-k], 4'b0010));
        tbl.push_back(mk(0, 1, 32'h0, 32'h88, 0, 3'd5, fl_tab[0], 4'b0001));
        tbl.push_back(mk(0, 0, 32'h0, 32'h88, 0, 3'd3, fl_tab[0], 4'b0000));
        // Both on empty: write only, then read it back.
        tbl.push_back(mk(1, 1, 32'hAB, 32'h88, 1, 3'd1, fl_tab[1], 4'b1001));
        tbl.push_back(mk(0, 1, 32'h0, 32'hAB, 0, 3'd4, fl_tab[0], 4'b0010));
        // Count 3, then ten simultaneous read+write cycles across pointer wrap.
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk(1, 0, 32'(k), 32'hAB, k, 3'd1, fl_tab[k], 4'b1000));
        for (int i = 0; i < 10; i++) begin
            exp_d = (i < 3) ? 32'(i + 1) : 32'hC0 + 32'(i - 3);
            tbl.push_back(mk(1, 1, 32'hC0 + 32'(i), exp_d, 3, 3'd6, fl_tab[3], 4'b1010));
        end
        // Refill to full, then both on full: read only.
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 0, 32'hD0 + 32'(k), 32'hC6, 4 + k, 3'd1, fl_tab[4+k], 4'b1000));
        tbl.push_back(mk(1, 1, 32'hEE, 32'hC7, 7, 3'd4, fl_tab[7], 4'b0110));
        // Drain: 0xEE must not appear.
        for (int k = 0; k < 7; k++) begin
            exp_d = (k < 2) ? 32'hC8 + 32'(k) : 32'hD0 + 32'(k - 2);
            tbl.push_back(mk(0, 1, 32'h0, exp_d, 6 - k, 3'd4, fl_tab[6-k], 4'b0010));
        end
        tbl.push_back(mk(0, 1, 32'h0, 32'hD4, 0, 3'd5, fl_tab[0], 4'b0001));

        // Reset held with a write pending: nothing stored, no ack.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_hold", observe(), RST_V);
        reset     = 1'b0;
        bus.wr_en = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].wr, tbl[i].rd, tbl[i].din);
            check($sformatf("vec%0d", i), observe(),
                  {tbl[i].dout, tbl[i].cnt, tbl[i].st, tbl[i].fl, tbl[i].ak});
        end

        // Asynchronous reset in the middle of a burst at count 5.
        for (int k = 0; k < 5; k++)
            cycle(1'b1, 1'b0, 32'hE0 + 32'(k));
        check("burst_cnt5", observe(), {32'hD4, 4'd5, 3'd1, fl_tab[5], 4'b1000});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", observe(), RST_V);
        @(posedge clk); #1;
        check("reset_edge_wr", observe(), RST_V);
        reset = 1'b0;
        cycle(1'b0, 1'b1, 32'h0);
        check("post_reset_rd", observe(), {32'h0, 4'd0, 3'd5, fl_tab[0], 4'b0001});
        cycle(1'b1, 1'b0, 32'h5A);
        cycle(1'b0, 1'b1, 32'h0);
        check("post_reset_wr_rd", observe(), {32'h5A, 4'd0, 3'd4, fl_tab[0], 4'b0010});
        cycle(1'b0, 1'b0, 32'h0);
        check("idle_clears", observe(), {32'h5A, 4'd0, 3'd3, fl_tab[0], 4'b0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
